// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing (data bits, parity, stop bits) feeding a
// show-ahead receive FIFO that records per-byte framing and parity status.
module uart_rx_fifo #(
    parameter int CLK_PER_HALF_BIT = 30,
    parameter int DATA_BITS        = 8,
    parameter int STOP_BITS        = 1,
    parameter int PARITY           = 0,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_ferr,
    output logic                          rd_perr,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int TW = $clog2(2 * CLK_PER_HALF_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_BITS + 2;

    localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_PER_HALF_BIT - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BREAK
    } state_e;

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 rxs;

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 push_q, push_d;
    logic                 tick;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 pop;
    logic                 full;
    logic                 wr_en;
    logic                 drop;
    logic [EW-1:0]        head;

    // rxd is asynchronous; everything downstream samples only rxs.
    always_comb begin
        sync1_d = rxd;
        sync2_d = sync1_q;
        rxs     = sync2_q;
        tick    = (timer_q == '0);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        data_d  = data_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        push_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    timer_d = HALF_LOAD;
                end
            end
            S_START: begin
                if (!tick) begin
                    timer_d = timer_q - TW'(1);
                end else if (rxs) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    timer_d = FULL_LOAD;
                    idx_d   = '0;
                    ferr_d  = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    data_d  = {rxs, data_q[DATA_BITS-1:1]};
                    timer_d = FULL_LOAD;
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_PAR: begin
                if (!tick) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    perr_d  = ((^data_q) ^ rxs) != (PARITY == 2);
                    timer_d = FULL_LOAD;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    ferr_d  = ferr_q | ~rxs;
                    timer_d = FULL_LOAD;
                    if (idx_q == LAST_STOP) begin
                        // A held-low line after a bad stop bit must not look like a new start.
                        push_d  = 1'b1;
                        idx_d   = '0;
                        state_d = (ferr_q | ~rxs) ? S_BREAK : S_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read handshake: rd_valid high means the head entry is presented; a pop happens on
    // any clock edge where rd_en && rd_valid, and rd_en is ignored while rd_valid is low.
    always_comb begin
        pop      = rd_en && (count_q != '0);
        full     = (count_q == DEPTH);
        wr_en    = push_q && (!full || pop);
        drop     = push_q && full && !pop;
        mem_d    = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {data_q, ferr_q, perr_q};
        end
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(wr_en) - CW'(pop);
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            push_q     <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            push_q     <= push_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        head     = mem_q[rd_ptr_q];
        rd_valid = (count_q != '0);
        rd_data  = rd_valid ? head[EW-1:2] : '0;
        rd_ferr  = rd_valid ? head[1] : 1'b0;
        rd_perr  = rd_valid ? head[0] : 1'b0;
        count    = count_q;
        overflow = overflow_q;
    end

endmodule
